// File: rtl/seq_detect_prog.sv
// seq_detect_prog -- programmable serial pattern detector.
//
// Watches a 1-bit serial stream (x qualified by in_valid) and flags every
// occurrence of a runtime-loaded pattern of 1..PAT_W bits. Supports
// overlapping and non-overlapping detection.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   x            serial data bit
//   in_valid     x is accepted this cycle
//   cfg_we       load cfg_pattern / cfg_len / cfg_overlap this cycle
//   cfg_pattern  new pattern, bit 0 is the last bit to arrive
//   cfg_len      new length (0 -> 1, >PAT_W -> PAT_W)
//   cfg_overlap  1 = overlapping detection, 0 = non-overlapping
//   cnt_clr      clear the match counter (wins over a simultaneous match)
//   y            combinational Mealy match flag for the current bit
//   y_q          y registered one cycle later
//   match_cnt    saturating match counter
module seq_detect_prog #(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1010),
  parameter int               RST_LEN = 4,
  parameter bit               RST_OVL = 1'b0,
  localparam int              LEN_W   = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             in_valid,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             y,
  output logic             y_q,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  // Active configuration
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] len;
  logic             ovl;

  // Stream history: newest accepted bit in hist[0]
  logic [PAT_W-1:0] hist;
  // Bits accepted since the last restart, saturating at PAT_W
  logic [LEN_W-1:0] fill;

  logic [PAT_W-1:0] win;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W:0]   fill_p1;
  logic [LEN_W-1:0] cfg_len_clamped;
  logic             fill_ok;
  logic             bits_eq;

  // The current bit completes the window; older bits come from history.
  assign win = {hist[PAT_W-2:0], x};

  // NOTE: every signal written in an always_comb gets a default on entry,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len));
    end
  end

  assign bits_eq = ((win ^ pat) & len_mask) == '0;

  // fill >= len-1, written as fill+1 >= len in one extra bit so that it
  // cannot underflow.
  assign fill_p1 = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};
  assign fill_ok = fill_p1 >= {1'b0, len};

  assign y = in_valid & ~cfg_we & ~rst & fill_ok & bits_eq;

  always_comb begin
    cfg_len_clamped = cfg_len;
    if (cfg_len == '0) begin
      cfg_len_clamped = LEN_ONE;
    end else if (cfg_len > LEN_MAX) begin
      cfg_len_clamped = LEN_MAX;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: hist is a plain shift register, so it is reset along with the
  // rest of the state; a stale history must never complete a match.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat       <= RST_PAT;
      len       <= LEN_W'(RST_LEN);
      ovl       <= RST_OVL;
      hist      <= '0;
      fill      <= '0;
      y_q       <= 1'b0;
      match_cnt <= '0;
    end else begin
      y_q <= y;

      if (cnt_clr) begin
        match_cnt <= '0;
      end else if (y && (match_cnt != '1)) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end

      if (cfg_we) begin
        pat  <= cfg_pattern;
        len  <= cfg_len_clamped;
        ovl  <= cfg_overlap;
        hist <= '0;
        fill <= '0;
      end else if (in_valid) begin
        hist <= win;
        if (y && !ovl) begin
          // Non-overlapping: the matched bits cannot seed the next match.
          fill <= '0;
        end else if (fill != LEN_MAX) begin
          fill <= fill + LEN_ONE;
        end
      end
    end
  end

endmodule
